// File: rtl/tdm_mux_arbiter_pkg.sv
// Shared constants and the round-robin pick helper for the TDM mux arbiter.
package tdm_mux_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int ADR_W = 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // First set request searching ptr, ptr+1, ... modulo N_REQ; descending loop so
  // the smallest offset from ptr is the last (winning) assignment.
  function automatic logic [ADR_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [ADR_W-1:0] ptr);
    logic [ADR_W-1:0] idx;
    rr_pick = ptr;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = ptr + ADR_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/tdm_mux_arbiter_mux4_sel.sv
// Existing 4:1 one-bit information multiplexer.
module mux4_sel
  import tdm_mux_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] inf_ul,
  input  logic [ADR_W-1:0] adr_ul,
  output logic             inf_raw
);

  assign inf_raw = inf_ul[adr_ul];

endmodule

// File: rtl/tdm_mux_arbiter.sv
// Round-robin, burst-bounded arbiter owning the address of the 4:1 mux.
module tdm_mux_arbiter
  import tdm_mux_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] inf_ul,
  output logic [ADR_W-1:0] adr_ul,
  output logic [N_REQ-1:0] gnt,
  output logic             inf_izl,
  output logic             izl_valid,
  output logic             busy
);

  logic [0:0]       state;
  logic [ADR_W-1:0] ptr;
  logic [ADR_W-1:0] win;
  logic [CNT_W-1:0] cnt;
  logic             rel;
  logic             mux_raw;

  assign win = rr_pick(req, ptr);
  // Requester drop, burst limit and disable collapse into one release.
  assign rel = !req[adr_ul] || (cnt == CNT_W'(MAX_BURST)) || !en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      adr_ul <= '0;
      gnt    <= '0;
      ptr    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en && |req) begin
            adr_ul <= win;
            gnt    <= N_REQ'(1) << win;
            cnt    <= CNT_W'(1);
            ptr    <= win + ADR_W'(1);
            state  <= ST_GRANT;
          end
        end
        default: begin
          // adr_ul is left alone on release so the mux address never glitches.
          if (rel) begin
            gnt   <= '0;
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  mux4_sel u_mux (
    .inf_ul  (inf_ul),
    .adr_ul  (adr_ul),
    .inf_raw (mux_raw)
  );

  assign izl_valid = |gnt;
  assign busy      = (state == ST_GRANT);
  assign inf_izl   = mux_raw & izl_valid;

endmodule

// File: tb/tb_tdm_mux_arbiter.sv
// Scoreboard bench: three arbiters (MAX_BURST 8, 2, 1) against a rule-level model.
module tb_tdm_mux_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] adr;
    logic       busy;
    logic       vld;
    logic       izl;
  } obs_t;
  typedef obs_t [2:0] obs3_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [3:0]       req = '0;
  logic [3:0]       inf = '0;
  logic [2:0][1:0]  adr_a;
  logic [2:0][3:0]  gnt_a;
  logic [2:0]       izl_a, vld_a, busy_a;

  int checks = 0;
  int errors = 0;

  obs3_t q[$];

  int mb[3]   = '{8, 2, 1};
  int own[3];
  int mptr[3];
  int mcnt[3];
  int madr[3];

  always #5 clk = ~clk;

  tdm_mux_arbiter #(.MAX_BURST(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .inf_ul(inf),
    .adr_ul(adr_a[0]), .gnt(gnt_a[0]), .inf_izl(izl_a[0]),
    .izl_valid(vld_a[0]), .busy(busy_a[0]));

  tdm_mux_arbiter #(.MAX_BURST(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .inf_ul(inf),
    .adr_ul(adr_a[1]), .gnt(gnt_a[1]), .inf_izl(izl_a[1]),
    .izl_valid(vld_a[1]), .busy(busy_a[1]));

  tdm_mux_arbiter #(.MAX_BURST(1), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .inf_ul(inf),
    .adr_ul(adr_a[2]), .gnt(gnt_a[2]), .inf_izl(izl_a[2]),
    .izl_valid(vld_a[2]), .busy(busy_a[2]));

  // Reference model: owner index (-1 when idle), next-search pointer, burst length.
  always @(posedge clk) begin
    obs3_t e;
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        own[d] = -1; mptr[d] = 0; mcnt[d] = 0; madr[d] = 0;
      end else if (own[d] < 0) begin
        if (en && req != 4'b0) begin
          for (int k = 0; k < 4; k++) begin
            int c;
            c = (mptr[d] + k) % 4;
            if (req[c] && own[d] < 0) begin
              own[d] = c; madr[d] = c; mcnt[d] = 1; mptr[d] = (c + 1) % 4;
            end
          end
        end
      end else if (!req[own[d]] || mcnt[d] == mb[d] || !en) begin
        own[d] = -1; mcnt[d] = 0;
      end else begin
        mcnt[d] = mcnt[d] + 1;
      end
      e[d].gnt  = (own[d] < 0) ? 4'b0 : (4'b1 << own[d]);
      e[d].adr  = 2'(madr[d]);
      e[d].busy = (own[d] >= 0);
      e[d].vld  = (own[d] >= 0);
      e[d].izl  = (own[d] >= 0) && inf[madr[d]];
    end
    q.push_back(e);
  end

  // Monitor: one observation per edge, sampled 1 time unit after it.
  always @(posedge clk) begin
    obs3_t e;
    obs_t  a;
    #1;
    if (q.size() == 0) begin
      errors++; checks++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = q.pop_front();
      for (int d = 0; d < 3; d++) begin
        a = '{gnt: gnt_a[d], adr: adr_a[d], busy: busy_a[d], vld: vld_a[d], izl: izl_a[d]};
        checks++;
        if (a !== e[d]) begin
          errors++;
          $display("FAIL sb_mb%0d t=%0t got gnt=%b adr=%0d busy=%b vld=%b izl=%b exp gnt=%b adr=%0d busy=%b vld=%b izl=%b",
                   mb[d], $time, a.gnt, a.adr, a.busy, a.vld, a.izl,
                   e[d].gnt, e[d].adr, e[d].busy, e[d].vld, e[d].izl);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h exp %0h", name, $time, got, exp);
    end
  endtask

  initial begin
    int vexp[13] = '{1,1,0,1,1,0,1,1,0,1,1,0,1};
    int aexp[13] = '{0,0,0,1,1,0,2,2,0,3,3,0,0};
    repeat (2) cyc();
    chk("reset_gnt", 8'(gnt_a[0]), 8'h0);
    chk("reset_busy", 8'(busy_a), 8'h0);
    rst_n = 1'b1;
    cyc();

    // Single requester
    en = 1'b1; req = 4'b0100; inf = 4'b0100;
    cyc();
    chk("single_adr", 8'(adr_a[0]), 8'd2);
    chk("single_gnt", 8'(gnt_a[0]), 8'b0100);
    chk("single_izl", 8'(izl_a[0]), 8'd1);
    req = 4'b0000;
    cyc();
    chk("drop_gnt", 8'(gnt_a[0]), 8'h0);
    chk("drop_izl", 8'(izl_a[0]), 8'h0);

    // Asynchronous reset mid-grant
    req = 4'b0100;
    cyc(); cyc();
    chk("pre_reset_gnt", 8'(gnt_a[0]), 8'b0100);
    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("async_rst_gnt", 8'(gnt_a[d]), 8'h0);
      chk("async_rst_adr", 8'(adr_a[d]), 8'h0);
    end
    chk("async_rst_busy", 8'(busy_a), 8'h0);
    cyc();
    rst_n = 1'b1; req = 4'b1111;

    // Round robin on MAX_BURST=2
    for (int i = 0; i < 13; i++) begin
      cyc();
      chk($sformatf("rr_vld_%0d", i), 8'(vld_a[1]), 8'(vexp[i]));
      if (vexp[i] != 0) chk($sformatf("rr_adr_%0d", i), 8'(adr_a[1]), 8'(aexp[i]));
    end

    // Burst limit on MAX_BURST=8
    req = 4'b0000;
    repeat (3) cyc();
    req = 4'b0001;
    for (int i = 1; i <= 18; i++) begin
      cyc();
      chk($sformatf("burst_%0d", i), 8'(gnt_a[0]),
          ((i >= 1 && i <= 8) || (i >= 10 && i <= 17)) ? 8'b0001 : 8'h0);
    end

    // Enable gating and ignoring late requesters
    req = 4'b0000;
    repeat (3) cyc();
    en = 1'b0; req = 4'b1010;
    repeat (3) begin
      cyc();
      chk("en_low_gnt", 8'(gnt_a[0]), 8'h0);
    end
    en = 1'b1;
    cyc();
    chk("en_grant", 8'(gnt_a[0]), 8'b0010);
    req = 4'b1011;
    repeat (3) begin
      cyc();
      chk("ignore_req0", 8'(gnt_a[0]), 8'b0010);
    end
    en = 1'b0;
    cyc();
    chk("en_drop_gnt", 8'(gnt_a[0]), 8'h0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      en    = ($urandom_range(0, 7) != 0);
      inf   = 4'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      cyc();
    end
    rst_n = 1'b1;
    repeat (2) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
